// File: rtl/scramble_pkg.sv
// Shared definitions for the 100BASE-X stream scrambler and its descrambler.
//   - LFSR width and tap positions for x^11 + x^9 + 1
//   - valid-field encodings for the 2-bit beat interface
//   - FSM state enum
//   - lfsr_ldd(): the two keystream bits produced from a given LFSR value
package scramble_pkg;

  localparam int LFSR_W = 11;

  // Taps: keystream bit 1 (earlier in time) and bit 0 (later in time).
  localparam int TAP_A_HI = 10;
  localparam int TAP_A_LO = 8;
  localparam int TAP_B_HI = 9;
  localparam int TAP_B_LO = 7;

  // Valid field: bit 0 set means exactly one bit (in data[1]); 10 means two.
  localparam logic [1:0] VLD_NONE    = 2'b00;
  localparam logic [1:0] VLD_TWO     = 2'b10;
  localparam int         VLD_ONE_BIT = 0;

  typedef enum logic [1:0] {
    ST_DISABLED = 2'd0,
    ST_RUN      = 2'd1,
    ST_RESEED   = 2'd2
  } state_e;

  function automatic logic [1:0] lfsr_ldd(input logic [LFSR_W-1:0] l);
    return {l[TAP_A_HI] ^ l[TAP_A_LO], l[TAP_B_HI] ^ l[TAP_B_LO]};
  endfunction

endpackage

// File: rtl/scramble_lfsr.sv
// Free-running 11-bit additive-scrambler LFSR (x^11 + x^9 + 1).
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset (resets to SEED)
//   adv_valid    beat valid field; 01/11 shift one bit, 10 shift two, 00 hold
//   load         take load_value next cycle (highest priority)
//   load_value   value used by load
//   reseed       take SEED next cycle (below load, above advance)
//   ldd          keystream bits for the current beat (from the registered value)
//   zero         registered LFSR value is all-zero
//   lfsr         registered LFSR value
module scramble_lfsr
  import scramble_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 11'h7ff
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        adv_valid,
  input  logic              load,
  input  logic [LFSR_W-1:0] load_value,
  input  logic              reseed,
  output logic [1:0]        ldd,
  output logic              zero,
  output logic [LFSR_W-1:0] lfsr
);

  logic [LFSR_W-1:0] lfsr_q, lfsr_d;

  always_comb begin
    ldd    = lfsr_ldd(lfsr_q);
    zero   = (lfsr_q == '0);
    lfsr_d = lfsr_q;
    if (load) begin
      lfsr_d = load_value;
    end else if (reseed) begin
      lfsr_d = SEED;
    end else if (adv_valid[VLD_ONE_BIT]) begin
      // Only the earlier keystream bit was consumed.
      lfsr_d = {lfsr_q[LFSR_W-2:0], ldd[1]};
    end else if (adv_valid == VLD_TWO) begin
      lfsr_d = {lfsr_q[LFSR_W-3:0], ldd};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign lfsr = lfsr_q;

endmodule

// File: rtl/scramble.sv
// Transmit-side 100BASE-X stream scrambler, up to two bits per clock.
// Ports:
//   clk, rst_n           clock and asynchronous active-low reset
//   unscrambled[1:0]     plaintext, bit 1 earlier in time
//   unscrambled_valid    00 none, bit 0 set one bit (in [1]), 10 two bits
//   enable               scrambling active; low freezes the LFSR
//   test_mode            bypass: output = plaintext, LFSR still advances
//   seed, load_seed      one-cycle strobe loading seed into the LFSR
//   scrambled[1:0]       ciphertext, one cycle after the input beat
//   scrambled_valid      input valid field delayed one cycle (00 when dropped)
//   ready                high while in RUN
//   reseed_count         saturating count of zero-guard reseeds
//   dbg_state, dbg_lfsr  FSM state and LFSR value for observation
//
// Beat semantics: a beat is offered when unscrambled_valid != 00. There is no
// backpressure; in RUN with enable high every offered beat is consumed that
// cycle, otherwise it is dropped and never reappears.
module scramble
  import scramble_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 11'h7ff
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        unscrambled,
  input  logic [1:0]        unscrambled_valid,
  input  logic              enable,
  input  logic              test_mode,
  input  logic [LFSR_W-1:0] seed,
  input  logic              load_seed,
  output logic [1:0]        scrambled,
  output logic [1:0]        scrambled_valid,
  output logic              ready,
  output logic [7:0]        reseed_count,
  output state_e            dbg_state,
  output logic [LFSR_W-1:0] dbg_lfsr
);

  state_e      state_q, state_d;
  logic [1:0]  scrambled_q, scrambled_d;
  logic [1:0]  scrambled_valid_q, scrambled_valid_d;
  logic        ready_q, ready_d;
  logic [7:0]  reseed_count_q, reseed_count_d;

  logic              beat_ok;
  logic              in_reseed;
  logic [1:0]        adv_valid;
  logic [1:0]        ldd;
  logic              lfsr_zero;
  logic [LFSR_W-1:0] lfsr;

  scramble_lfsr #(.SEED(SEED)) u_lfsr (
    .clk        (clk),
    .rst_n      (rst_n),
    .adv_valid  (adv_valid),
    .load       (load_seed),
    .load_value (seed),
    .reseed     (in_reseed),
    .ldd        (ldd),
    .zero       (lfsr_zero),
    .lfsr       (lfsr)
  );

  always_comb begin
    beat_ok   = (state_q == ST_RUN) && enable;
    in_reseed = (state_q == ST_RESEED);
    adv_valid = beat_ok ? unscrambled_valid : VLD_NONE;

    state_d = state_q;
    case (state_q)
      ST_DISABLED: state_d = enable ? ST_RUN : ST_DISABLED;
      // Zero guard wins over disable so a stuck LFSR is never carried
      // through a pause.
      ST_RUN:      state_d = lfsr_zero ? ST_RESEED : (enable ? ST_RUN : ST_DISABLED);
      ST_RESEED:   state_d = enable ? ST_RUN : ST_DISABLED;
      default:     state_d = ST_DISABLED;
    endcase

    scrambled_valid_d = beat_ok ? unscrambled_valid : VLD_NONE;
    scrambled_d       = 2'b00;
    if (beat_ok) begin
      scrambled_d = test_mode ? unscrambled : (unscrambled ^ ldd);
    end

    // ready is registered from the next state so it tracks RUN exactly.
    ready_d = (state_d == ST_RUN);

    reseed_count_d = reseed_count_q;
    if (in_reseed && (reseed_count_q != 8'hff)) begin
      reseed_count_d = reseed_count_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q           <= ST_DISABLED;
      scrambled_q       <= 2'b00;
      scrambled_valid_q <= VLD_NONE;
      ready_q           <= 1'b0;
      reseed_count_q    <= 8'd0;
    end else begin
      state_q           <= state_d;
      scrambled_q       <= scrambled_d;
      scrambled_valid_q <= scrambled_valid_d;
      ready_q           <= ready_d;
      reseed_count_q    <= reseed_count_d;
    end
  end

  assign scrambled       = scrambled_q;
  assign scrambled_valid = scrambled_valid_q;
  assign ready           = ready_q;
  assign reseed_count    = reseed_count_q;
  assign dbg_state       = state_q;
  assign dbg_lfsr        = lfsr;

endmodule

// File: tb/tb_scramble.sv
// Bench for scramble. Reference model keeps the keystream as a bit history:
// each new keystream bit is s[n] = s[n-11] ^ s[n-9], and the last 11 bits
// form the LFSR value. Plaintext bits are XORed with successive keystream bits.
module tb_scramble;
  import scramble_pkg::*;

  localparam logic [10:0] SEED = 11'h7ff;
  localparam int M_DIS = 0;
  localparam int M_RUN = 1;
  localparam int M_RESEED = 2;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  unscrambled, unscrambled_valid;
  logic        enable, test_mode, load_seed;
  logic [10:0] seed;
  logic [1:0]  scrambled, scrambled_valid;
  logic        ready;
  logic [7:0]  reseed_count;
  state_e      dbg_state;
  logic [10:0] dbg_lfsr;

  always #5 clk = ~clk;

  scramble #(.SEED(SEED)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .unscrambled       (unscrambled),
    .unscrambled_valid (unscrambled_valid),
    .enable            (enable),
    .test_mode         (test_mode),
    .seed              (seed),
    .load_seed         (load_seed),
    .scrambled         (scrambled),
    .scrambled_valid   (scrambled_valid),
    .ready             (ready),
    .reseed_count      (reseed_count),
    .dbg_state         (dbg_state),
    .dbg_lfsr          (dbg_lfsr)
  );

  // ---------------- scoreboard / model state ----------------
  int checks = 0;
  int errors = 0;

  logic [3:0] exp_q[$];      // {valid[1:0], data[1:0]} with unused data bit = 0
  bit         ks[$];         // last 11 keystream bits, ks[0] oldest
  int         m_state;
  logic [7:0] m_cnt;
  logic       m_ready;
  bit         track = 1'b0;
  bit         tx_bits[$];
  bit         rx_bits[$];

  typedef struct {
    logic [1:0]  u, v;
    logic        en, tm, ld;
    logic [10:0] sd;
    logic [1:0]  es, ev;
    logic [10:0] elfsr;
    logic        erdy;
    logic [7:0]  ecnt;
  } vec_t;
  vec_t vecs[17];

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [10:0] ks_value();
    logic [10:0] val;
    for (int i = 0; i < 11; i++) val[10-i] = ks[i];
    return val;
  endfunction

  task automatic ks_load(input logic [10:0] val);
    ks.delete();
    for (int i = 0; i < 11; i++) ks.push_back(val[10-i]);
  endtask

  task automatic ks_next(output bit k);
    k = ks[0] ^ ks[2];
    ks.push_back(k);
    void'(ks.pop_front());
  endtask

  task automatic model_reset();
    ks_load(SEED);
    m_state = M_DIS;
    m_cnt   = 8'd0;
    m_ready = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_step(input logic [1:0] u, v, input logic en, tm, ld,
                            input logic [10:0] sd);
    bit         zero, beat, k;
    int         nb, nxt;
    logic [1:0] ov, od;
    zero = (ks_value() == 11'd0);
    beat = (m_state == M_RUN) && en;
    ov = 2'b00;
    od = 2'b00;
    nb = 0;
    if (beat) begin
      ov = v;
      if (v[0]) nb = 1;
      else if (v[1]) nb = 2;
      if (nb >= 1) begin
        ks_next(k);
        od[1] = tm ? u[1] : (u[1] ^ k);
        if (track) tx_bits.push_back(u[1]);
      end
      if (nb == 2) begin
        ks_next(k);
        od[0] = tm ? u[0] : (u[0] ^ k);
        if (track) tx_bits.push_back(u[0]);
      end
    end
    if (m_state == M_RESEED && m_cnt != 8'hff) m_cnt = m_cnt + 8'd1;
    if (ld) ks_load(sd);
    else if (m_state == M_RESEED) ks_load(SEED);
    case (m_state)
      M_DIS:   nxt = en ? M_RUN : M_DIS;
      M_RUN:   nxt = zero ? M_RESEED : (en ? M_RUN : M_DIS);
      default: nxt = en ? M_RUN : M_DIS;
    endcase
    m_state = nxt;
    m_ready = (nxt == M_RUN);
    exp_q.push_back({ov, od});
  endtask

  task automatic check_outputs();
    logic [3:0] e;
    logic [1:0] mask;
    if (exp_q.size() == 0) begin
      cmp("scoreboard_empty", 1, 0);
      return;
    end
    e = exp_q.pop_front();
    mask = (e[3:2] == 2'b10) ? 2'b11 : ((e[3:2] == 2'b00) ? 2'b00 : 2'b10);
    cmp("valid", scrambled_valid, e[3:2]);
    if (mask != 2'b00) cmp("data", scrambled & mask, e[1:0]);
    cmp("ready", ready, m_ready);
    cmp("reseed_count", reseed_count, m_cnt);
    cmp("lfsr", dbg_lfsr, ks_value());
    if (track && scrambled_valid != 2'b00) begin
      rx_bits.push_back(scrambled[1]);
      if (scrambled_valid == 2'b10) rx_bits.push_back(scrambled[0]);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input logic [1:0] u, v, input logic en, tm, ld,
                      input logic [10:0] sd);
    unscrambled       = u;
    unscrambled_valid = v;
    enable            = en;
    test_mode         = tm;
    load_seed         = ld;
    seed              = sd;
    @(posedge clk);
    #1;
    model_step(u, v, en, tm, ld, sd);
    check_outputs();
  endtask

  task automatic check_reset_values(input string tag);
    cmp({tag, "_scrambled"}, scrambled, 2'b00);
    cmp({tag, "_valid"}, scrambled_valid, 2'b00);
    cmp({tag, "_ready"}, ready, 1'b0);
    cmp({tag, "_count"}, reseed_count, 8'd0);
    cmp({tag, "_lfsr"}, dbg_lfsr, SEED);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    unscrambled = 2'b00; unscrambled_valid = 2'b00;
    enable = 1'b0; test_mode = 1'b0; load_seed = 1'b0; seed = 11'd0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check_reset_values("reset");
    #2 rst_n = 1'b1;
  endtask

  task automatic rand_beat(input logic tm, input int en_pct, input int ld_pct);
    logic [1:0]  u, v;
    logic        en, ld;
    logic [10:0] sd;
    u  = 2'($urandom_range(0, 3));
    v  = 2'($urandom_range(0, 3));
    en = ($urandom_range(0, 99) < en_pct);
    ld = ($urandom_range(0, 99) < ld_pct);
    sd = ($urandom_range(0, 3) == 0) ? 11'd0 : 11'($urandom_range(0, 2047));
    step(u, v, en, tm, ld, sd);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    vecs[0]  = '{2'b11, 2'b10, 1'b1, 1'b0, 1'b0, 11'h000, 2'b00, 2'b00, 11'h7ff, 1'b1, 8'd0};
    vecs[1]  = '{2'b11, 2'b10, 1'b1, 1'b0, 1'b0, 11'h000, 2'b11, 2'b10, 11'h7fc, 1'b1, 8'd0};
    vecs[2]  = '{2'b00, 2'b00, 1'b1, 1'b0, 1'b1, 11'h100, 2'b00, 2'b00, 11'h100, 1'b1, 8'd0};
    vecs[3]  = '{2'b00, 2'b10, 1'b1, 1'b0, 1'b0, 11'h000, 2'b10, 2'b10, 11'h402, 1'b1, 8'd0};
    vecs[4]  = '{2'b01, 2'b01, 1'b1, 1'b0, 1'b0, 11'h000, 2'b10, 2'b01, 11'h005, 1'b1, 8'd0};
    vecs[5]  = '{2'b11, 2'b11, 1'b1, 1'b0, 1'b0, 11'h000, 2'b10, 2'b11, 11'h00a, 1'b1, 8'd0};
    vecs[6]  = '{2'b11, 2'b10, 1'b0, 1'b0, 1'b0, 11'h000, 2'b00, 2'b00, 11'h00a, 1'b0, 8'd0};
    vecs[7]  = '{2'b11, 2'b10, 1'b0, 1'b0, 1'b0, 11'h000, 2'b00, 2'b00, 11'h00a, 1'b0, 8'd0};
    vecs[8]  = '{2'b00, 2'b10, 1'b1, 1'b0, 1'b0, 11'h000, 2'b00, 2'b00, 11'h00a, 1'b1, 8'd0};
    vecs[9]  = '{2'b00, 2'b10, 1'b1, 1'b0, 1'b0, 11'h000, 2'b00, 2'b10, 11'h028, 1'b1, 8'd0};
    vecs[10] = '{2'b10, 2'b10, 1'b1, 1'b1, 1'b0, 11'h000, 2'b10, 2'b10, 11'h0a0, 1'b1, 8'd0};
    vecs[11] = '{2'b00, 2'b10, 1'b1, 1'b0, 1'b0, 11'h000, 2'b01, 2'b10, 11'h281, 1'b1, 8'd0};
    vecs[12] = '{2'b00, 2'b10, 1'b1, 1'b0, 1'b0, 11'h000, 2'b00, 2'b10, 11'h204, 1'b1, 8'd0};
    vecs[13] = '{2'b01, 2'b10, 1'b1, 1'b1, 1'b0, 11'h000, 2'b01, 2'b10, 11'h011, 1'b1, 8'd0};
    vecs[14] = '{2'b00, 2'b00, 1'b1, 1'b0, 1'b1, 11'h000, 2'b00, 2'b00, 11'h000, 1'b1, 8'd0};
    vecs[15] = '{2'b11, 2'b10, 1'b1, 1'b0, 1'b0, 11'h000, 2'b11, 2'b10, 11'h000, 1'b0, 8'd0};
    vecs[16] = '{2'b11, 2'b10, 1'b1, 1'b0, 1'b0, 11'h000, 2'b00, 2'b00, 11'h7ff, 1'b1, 8'd1};

    do_reset();

    // Directed vectors from reset.
    for (int i = 0; i < 17; i++) begin
      logic [1:0] mask;
      step(vecs[i].u, vecs[i].v, vecs[i].en, vecs[i].tm, vecs[i].ld, vecs[i].sd);
      mask = (vecs[i].ev == 2'b10) ? 2'b11 : ((vecs[i].ev == 2'b00) ? 2'b00 : 2'b10);
      cmp($sformatf("vec%0d_valid", i), scrambled_valid, vecs[i].ev);
      if (mask != 2'b00) cmp($sformatf("vec%0d_data", i), scrambled & mask, vecs[i].es);
      cmp($sformatf("vec%0d_lfsr", i), dbg_lfsr, vecs[i].elfsr);
      cmp($sformatf("vec%0d_ready", i), ready, vecs[i].erdy);
      cmp($sformatf("vec%0d_count", i), reseed_count, vecs[i].ecnt);
    end

    // Bypass: 500 beats with test_mode high, then 500 scrambled.
    for (int i = 0; i < 500; i++) rand_beat(1'b1, 100, 0);
    for (int i = 0; i < 500; i++) rand_beat(1'b0, 100, 0);

    // Mixed random: enable drops, seed loads (some zero), test_mode toggling.
    for (int i = 0; i < 1500; i++) rand_beat(1'($urandom_range(0, 1)), 90, 3);

    // Reseed counter saturation.
    do_reset();
    step(2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 11'd0);
    for (int i = 0; i < 300; i++) begin
      step(2'b00, 2'b00, 1'b1, 1'b0, 1'b1, 11'd0);
      step(2'b11, 2'b10, 1'b1, 1'b0, 1'b0, 11'd0);
      step(2'b11, 2'b10, 1'b1, 1'b0, 1'b0, 11'd0);
    end
    cmp("count_saturated", reseed_count, 8'hff);

    // Loopback through a bench descrambler locked on 64 idle (all-ones) bits.
    do_reset();
    step(2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 11'd0);
    tx_bits.delete();
    rx_bits.delete();
    track = 1'b1;
    for (int i = 0; i < 32; i++) step(2'b11, 2'b10, 1'b1, 1'b0, 1'b0, 11'd0);
    for (int i = 0; i < 200; i++)
      step(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 1'b1, 1'b0, 1'b0, 11'd0);
    track = 1'b0;
    cmp("loopback_len", rx_bits.size(), tx_bits.size());
    begin
      bit dq[$];
      bit k, p;
      int bad;
      bad = 0;
      for (int i = 0; i < rx_bits.size() && i < tx_bits.size(); i++) begin
        if (i < 11) begin
          dq.push_back(rx_bits[i] ^ 1'b1);
        end else begin
          k = dq[0] ^ dq[2];
          dq.push_back(k);
          void'(dq.pop_front());
          p = rx_bits[i] ^ k;
          if (p != tx_bits[i]) bad++;
        end
      end
      cmp("loopback_bit_errors", bad, 0);
    end

    // Enable gap mid-stream, then asynchronous reset between edges.
    do_reset();
    step(2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 11'd0);
    for (int i = 0; i < 20; i++) rand_beat(1'b0, 100, 0);
    for (int i = 0; i < 10; i++) begin
      step(2'($urandom_range(0, 3)), 2'b10, 1'b0, 1'b0, 1'b0, 11'd0);
      cmp("gap_valid", scrambled_valid, 2'b00);
    end
    for (int i = 0; i < 20; i++) rand_beat(1'b0, 100, 0);
    step(2'b11, 2'b10, 1'b1, 1'b0, 1'b1, 11'h555);
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    check_reset_values("async_reset");
    @(posedge clk);
    #3 rst_n = 1'b1;
    step(2'b11, 2'b10, 1'b1, 1'b0, 1'b0, 11'd0);
    cmp("post_reset_drop", scrambled_valid, 2'b00);
    step(2'b11, 2'b10, 1'b1, 1'b0, 1'b0, 11'd0);
    cmp("post_reset_first_beat", scrambled, 2'b11);
    cmp("post_reset_lfsr", dbg_lfsr, 11'h7fc);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/scramble.md
# scramble

Transmit-side 100BASE-X stream scrambler. It XORs the 4B/5B-encoded, NRZI-bound bit stream with the output of an 11-bit free-running LFSR (x^11 + x^9 + 1), two bits per clock at most. The receive-side descrambler self-synchronises to this stream. The block sits between the 4B/5B encoder and the NRZI/serialiser. It carries a seed load, a bypass for conformance testing, and a lock-up guard that reseeds the LFSR if it ever reaches the all-zero state.

## Interface

Parameters:
- SEED, 11'h7ff, LFSR value after reset and on guard reseed; must be nonzero.

Ports:
- clk  in  1  single clock, all logic on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- unscrambled  in  2  plaintext bits; bit 1 is earlier in time.
- unscrambled_valid  in  2  00 none; bit 0 set: one bit valid in unscrambled[1]; 10: both bits valid. 11 behaves as 01 (bit 0 has priority).
- enable  in  1  high: scrambling active; low: LFSR frozen, output invalid.
- test_mode  in  1  high: bypass, output = plaintext; LFSR still advances.
- seed  in  11  value for load_seed.
- load_seed  in  1  single-cycle strobe: LFSR takes seed next cycle.
- scrambled  out  2  ciphertext, aligned as unscrambled.
- scrambled_valid  out  2  copy of unscrambled_valid, delayed one cycle.
- ready  out  1  high in RUN state.
- reseed_count  out  8  saturating count of guard reseeds.

## Operation

- ldd = { lfsr[8]^lfsr[10], lfsr[7]^lfsr[9] }.
- Scrambled data: scrambled_next = unscrambled ^ ldd, or unscrambled when test_mode is high.
- LFSR advance:
  - One bit valid: lfsr_next = {lfsr[9:0], ldd[1]}.
  - Two bits valid: lfsr_next = {lfsr[8:0], ldd}.
  - None valid: hold.
- The plaintext never feeds the LFSR (free-running additive scrambler).
- FSM states: DISABLED, RUN, RESEED.
  - DISABLED:
    - Entered on reset.
    - Exits to RUN when enable is high.
    - ready = 0; output valid forced to 00; LFSR holds.
  - RUN:
    - Scrambles beats as above.
    - Goes to DISABLED when enable is low.
    - Goes to RESEED when lfsr == 0 (checked on the registered value).
  - RESEED:
    - One cycle only; lfsr <= SEED; reseed_count increments, saturating at 8'hff.
    - Input beats in this cycle are dropped (scrambled_valid = 00 next cycle).
    - Then goes to RUN if enable is high, else DISABLED.
- load_seed:
  - Accepted in any state.
  - The LFSR takes seed in place of the advance. The current beat is still scrambled with the old lfsr.
  - A seed of 0 is accepted; the guard catches it on the following cycle.
- Priority: reset > load_seed > RESEED > advance.
- enable falling mid-stream: that cycle's beat is dropped; LFSR state is preserved for resume.

## Timing

- Reset values:
  - scrambled = 00, scrambled_valid = 00, ready = 0, reseed_count = 0.
  - lfsr = SEED, state = DISABLED.
- Latency is 1 cycle: the beat at edge N appears on scrambled and scrambled_valid after edge N+1.
- No backpressure: a valid beat in RUN is always consumed.
- ready rises the cycle after enable is first sampled high.
- The zero guard costs 1 dropped cycle; after it, ready = 0 for that cycle.
- Asynchronous reset deassertion mid-stream: the first beat after release is dropped, because the block is in DISABLED.

## Structure

- Shared package holds:
  - LFSR width (11) and the tap positions (10, 8 / 9, 7), shared with the descrambler.
  - Valid-field encodings and the FSM state enum.
- Optional sub-module scramble_lfsr: holds the LFSR register plus the ldd and advance logic. It takes valid, load, and load value as inputs and outputs ldd and zero. It is reusable by the descrambler refactor.

## Test plan

- Reset, enable=1, SEED=11'h7ff, unscrambled=11, valid=10 -> scrambled=11 one cycle later, lfsr=11'h7fc, ready=1.
- load_seed with seed=11'h100, then unscrambled=00, valid=10 -> scrambled=10, lfsr=11'h402.
- test_mode=1 with a random stream of 500 beats -> scrambled equals the input; the LFSR sequence is identical to the test_mode=0 run.
- load_seed with seed=0 -> next cycle RESEED, that beat dropped, lfsr=SEED, reseed_count=1. Repeat 300 times -> reseed_count saturates at 8'hff.
- Loopback into the descrambler with 64 idle bits, then mixed 1-bit and 2-bit valid frames -> descrambler locks and the plaintext is recovered bit-exact.
- enable dropped for 10 cycles mid-frame, then rst_n pulsed asynchronously between edges -> outputs invalid during the gap; resume uses the held lfsr; reset returns all outputs to their reset values immediately.
